// File: rtl/gear_shift_pkg.sv
// gear_shift_pkg: shared types and default constants for the gear shift controller.
//   gs_state_t   : controller state encoding (OFF, IDLE, DRIVE, COOL)
//   *_DEF        : default parameter values used by gear_shift_ctrl and gs_hold_cnt
package gear_shift_pkg;

  typedef enum logic [1:0] {
    OFF,
    IDLE,
    DRIVE,
    COOL
  } gs_state_t;

  localparam int unsigned RPM_W_DEF     = 8;
  localparam int unsigned NUM_GEARS_DEF = 5;
  localparam int unsigned UP_TH_DEF     = 200;
  localparam int unsigned DN_TH_DEF     = 80;
  localparam int unsigned HOLD_CYC_DEF  = 4;
  localparam int unsigned COOL_CYC_DEF  = 8;

endpackage

// File: rtl/gs_hold_cnt.sv
// gs_hold_cnt: saturating count of consecutive qualifying samples.
//   clk   in  clock, rising edge
//   reset in  asynchronous active-low reset
//   qual  in  current sample qualifies; a non-qualifying sample empties the count
//   clr   in  restart the run: earlier samples are discarded, this one still counts if qual
//   done  out this sample is the HOLD_CYC-th (or later) consecutive qualifying one
module gs_hold_cnt
  import gear_shift_pkg::*;
#(
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic qual,
  input  logic clr,
  output logic done
);

  localparam int unsigned CW = $clog2(HOLD_CYC + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] base;

  always_comb begin
    base = clr ? '0 : cnt;
    done = qual && (base >= CW'(HOLD_CYC - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!qual) begin
      cnt <= '0;
    end else if (base != CW'(HOLD_CYC)) begin
      cnt <= base + 1'b1;
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/gear_shift_ctrl.sv
// gear_shift_ctrl: automatic gearbox controller with hold filter and post-shift cooldown.
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset
//   A        in  ignition (1 = on)
//   rpm      in  engine rpm, sampled every edge
//   kick     in  kickdown request (only when GEAR_SHIFT_KICKDOWN_EN is defined)
//   gear     out current gear, 0 = neutral
//   AC       out engine running
//   shift_up out one-cycle upshift pulse
//   shift_dn out one-cycle downshift pulse
//   busy     out high while cooling down after a shift
// Build option: define GEAR_SHIFT_KICKDOWN_EN to add the kick port and kickdown logic.
module gear_shift_ctrl
  import gear_shift_pkg::*;
#(
  parameter int unsigned RPM_W     = RPM_W_DEF,
  parameter int unsigned NUM_GEARS = NUM_GEARS_DEF,
  parameter int unsigned UP_TH     = UP_TH_DEF,
  parameter int unsigned DN_TH     = DN_TH_DEF,
  parameter int unsigned HOLD_CYC  = HOLD_CYC_DEF,
  parameter int unsigned COOL_CYC  = COOL_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A,
  input  logic [RPM_W-1:0] rpm,
`ifdef GEAR_SHIFT_KICKDOWN_EN
  input  logic             kick,
`endif
  output logic [3:0]       gear,
  output logic             AC,
  output logic             shift_up,
  output logic             shift_dn,
  output logic             busy
);

  if (NUM_GEARS < 2 || NUM_GEARS > 15) begin : g_bad_num_gears
    $error("gear_shift_ctrl: NUM_GEARS must be in 2..15");
  end
  if (DN_TH >= UP_TH) begin : g_bad_thresholds
    $error("gear_shift_ctrl: DN_TH must be below UP_TH");
  end
  if (HOLD_CYC < 1 || COOL_CYC < 1) begin : g_bad_cycles
    $error("gear_shift_ctrl: HOLD_CYC and COOL_CYC must be at least 1");
  end

  localparam int unsigned CCW = $clog2(COOL_CYC + 1);
  localparam logic [3:0]  NG4 = 4'(NUM_GEARS);

  gs_state_t      state, state_n;
  logic [3:0]     gear_n;
  logic           up_n, dn_n;
  logic [CCW-1:0] cool_q, cool_n;
  logic           up_cond, dn_cond, qual, dir_up, clr, done;
  logic           prev_up, prev_dn;

  // Direction memory lets a sample that reverses direction restart the run
  // instead of extending the opposite one.
  always_comb begin
    up_cond = rpm >= RPM_W'(UP_TH);
    dn_cond = rpm < RPM_W'(DN_TH);
    qual    = 1'b0;
    dir_up  = 1'b1;
    if (A) begin
      if (state == IDLE) begin
        qual   = !dn_cond;
        dir_up = 1'b1;
      end else if (state == DRIVE) begin
        qual   = up_cond | dn_cond;
        dir_up = up_cond;
      end
    end
    clr = qual & ((dir_up & prev_dn) | (!dir_up & prev_up));
  end

  gs_hold_cnt #(
    .HOLD_CYC(HOLD_CYC)
  ) u_hold (
    .clk  (clk),
    .reset(reset),
    .qual (qual),
    .clr  (clr),
    .done (done)
  );

  always_comb begin
    state_n = state;
    gear_n  = gear;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    cool_n  = cool_q;
    if (!A) begin
      state_n = OFF;
      gear_n  = '0;
      cool_n  = '0;
    end else begin
      unique case (state)
        OFF: state_n = IDLE;
        IDLE: begin
          if (done) begin
            gear_n  = 4'd1;
            up_n    = 1'b1;
            state_n = COOL;
            cool_n  = '0;
          end
        end
        DRIVE: begin
`ifdef GEAR_SHIFT_KICKDOWN_EN
          if (kick && gear >= 4'd3) begin
            gear_n  = gear - 4'd2;
            dn_n    = 1'b1;
            state_n = COOL;
            cool_n  = '0;
          end else
`endif
          if (done && dir_up) begin
            if (gear < NG4) begin
              gear_n  = gear + 4'd1;
              up_n    = 1'b1;
              state_n = COOL;
              cool_n  = '0;
            end
          end else if (done) begin
            gear_n  = gear - 4'd1;
            dn_n    = 1'b1;
            state_n = (gear == 4'd1) ? IDLE : COOL;
            cool_n  = '0;
          end
        end
        COOL: begin
          if (cool_q == CCW'(COOL_CYC - 1)) begin
            state_n = DRIVE;
            cool_n  = '0;
          end else begin
            cool_n = cool_q + 1'b1;
          end
        end
        default: state_n = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= OFF;
      gear     <= '0;
      AC       <= 1'b0;
      shift_up <= 1'b0;
      shift_dn <= 1'b0;
      busy     <= 1'b0;
      cool_q   <= '0;
      prev_up  <= 1'b0;
      prev_dn  <= 1'b0;
    end else begin
      state    <= state_n;
      gear     <= gear_n;
      AC       <= (state_n != OFF);
      shift_up <= up_n;
      shift_dn <= dn_n;
      busy     <= (state_n == COOL);
      cool_q   <= cool_n;
      prev_up  <= qual & dir_up;
      prev_dn  <= qual & !dir_up;
    end
  end

endmodule
